// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver states, the common baud divisor
// and the usart_ctrl command encodings.
package usart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 138;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam logic [1:0] NOP      = 2'd0;
   localparam logic [1:0] SET_CTRL = 2'd1;
   localparam logic [1:0] SET_DATA = 2'd2;
   localparam logic [1:0] GET_DATA = 2'd3;

endpackage

// File: rtl/usart_rx_if.sv
// Receiver-to-consumer bundle: held byte with valid/ack handshake,
// plus line status flags.
interface usart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun_err;
   logic       rx_ack;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_busy,
      output frame_err,
      output overrun_err,
      input  rx_ack
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rx_busy,
      input  frame_err,
      input  overrun_err,
      output rx_ack
   );
endinterface

// File: rtl/usart_sync.sv
// N-flop synchroniser for asynchronous inputs; flops reset to 1 so an
// idle-high line reads idle straight out of reset.
module usart_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[N-2:0], d_i};
      end
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/usart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a clock-count bit period,
// byte held in a valid/ack register with framing and overrun flags.
module usart_rx
   import usart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   rx_pin,
   usart_rx_if.master rx
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

   logic          rx_s;
   rx_state_t     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    shreg_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          busy_q;
   logic          ferr_q;
   logic          ovr_q;
   logic          dlv_q;

   usart_sync #(.N(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (rx_pin),
      .q_o   (rx_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         dlv_q   <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         dlv_q  <= 1'b0;
         cnt_q  <= cnt_q + 1'b1;

         // a delivery in the same cycle as an ack keeps valid set
         if (dlv_q) begin
            data_q  <= shreg_q;
            valid_q <= 1'b1;
            if (valid_q && !rx.rx_ack) begin
               ovr_q <= 1'b1;
            end else if (rx.rx_ack) begin
               ovr_q <= 1'b0;
            end
         end else if (rx.rx_ack) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
         end

         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rx_s) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                     idx_q   <= '0;
                  end
               end
            end
            DATA: begin
               if (cnt_q == LAST) begin
                  cnt_q          <= '0;
                  shreg_q[idx_q] <= rx_s;
                  idx_q          <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end
            end
            STOP: begin
               if (cnt_q == LAST) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     dlv_q   <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= BREAK;
                  end
               end
            end
            BREAK: begin
               // held-low line must return high before a new start
               cnt_q <= '0;
               if (rx_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx.rx_data     = data_q;
   assign rx.rx_valid    = valid_q;
   assign rx.rx_busy     = busy_q;
   assign rx.frame_err   = ferr_q;
   assign rx.overrun_err = ovr_q;

endmodule

// File: tb/tb_usart_rx.sv
// Scenario bench for usart_rx: frames driven on rx_pin, expected bytes
// queued at send time and compared once the stop bit has gone by.
module tb_usart_rx;

   localparam int CPB = 138;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic rx_pin = 1'b1;

   usart_rx_if rif();

   usart_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .rx_pin (rx_pin),
      .rx     (rif)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t_fall = 0;
   int t_rise = -1;
   int ferr_cyc = 0;
   bit prev_v = 1'b0;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rif.rx_valid && !prev_v) t_rise = cyc;
      prev_v = rif.rx_valid;
      if (rif.frame_err) ferr_cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] next_exp();
      logic [7:0] e;
      e = 8'hxx;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      return e;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int per);
      if (stop) exp_q.push_back(b);
      rx_pin = 1'b0;
      t_fall = cyc;
      repeat (per) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (per) @(negedge clk);
      end
      rx_pin = stop;
      repeat (per) @(negedge clk);
   endtask

   task automatic do_ack();
      rif.rx_ack = 1'b1;
      @(negedge clk);
      rif.rx_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({rif.rx_data, rif.rx_valid, rif.rx_busy, rif.frame_err,
           rif.overrun_err} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_state: got %h/%b%b%b%b required 00/0000",
                  rif.rx_data, rif.rx_valid, rif.rx_busy,
                  rif.frame_err, rif.overrun_err);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (rif.rx_valid || rif.rx_busy || rif.frame_err) bad++;
      end
      n_cmp++;
      if (bad != 0 || rif.rx_data !== 8'h00) begin
         n_bad++;
         $display("FAIL idle: got %0d bad cycles data %h required 0 / 00",
                  bad, rif.rx_data);
      end
   endtask

   task automatic test_single();
      logic [7:0] e;
      int lat;
      t_rise = -1;
      send_frame(8'hA5, 1'b1, CPB);
      e = next_exp();
      lat = t_rise - t_fall;
      n_cmp++;
      if (t_rise < 0 || lat < 1313 || lat > 1315) begin
         n_bad++;
         $display("FAIL latency: got %0d required 1314+-1", lat);
      end
      n_cmp++;
      if (rif.rx_valid !== 1'b1 || rif.rx_data !== e) begin
         n_bad++;
         $display("FAIL single_data: got %b/%h required 1/%h",
                  rif.rx_valid, rif.rx_data, e);
      end
      do_ack();
      n_cmp++;
      if (rif.rx_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL single_ack: got valid %b required 0", rif.rx_valid);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] e;
      ferr_cyc = 0;
      rx_pin = 1'b0;
      repeat (40) @(negedge clk);
      rx_pin = 1'b1;
      repeat (200) @(negedge clk);
      n_cmp++;
      if (rif.rx_valid || rif.rx_busy || ferr_cyc != 0) begin
         n_bad++;
         $display("FAIL glitch: got valid %b busy %b ferr %0d required 0 0 0",
                  rif.rx_valid, rif.rx_busy, ferr_cyc);
      end
      send_frame(8'h3C, 1'b1, CPB);
      e = next_exp();
      n_cmp++;
      if (rif.rx_valid !== 1'b1 || rif.rx_data !== e) begin
         n_bad++;
         $display("FAIL glitch_next: got %b/%h required 1/%h",
                  rif.rx_valid, rif.rx_data, e);
      end
      do_ack();
   endtask

   task automatic test_frame_err();
      logic [7:0] e;
      ferr_cyc = 0;
      send_frame(8'h55, 1'b0, CPB);
      repeat (500) @(negedge clk);
      n_cmp++;
      if (rif.rx_busy !== 1'b1 || rif.rx_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL break_hold: got busy %b valid %b required 1 0",
                  rif.rx_busy, rif.rx_valid);
      end
      rx_pin = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (ferr_cyc != 1 || rif.rx_valid !== 1'b0 || rif.rx_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL frame_err: got pulses %0d valid %b busy %b required 1 0 0",
                  ferr_cyc, rif.rx_valid, rif.rx_busy);
      end
      send_frame(8'h0F, 1'b1, CPB);
      e = next_exp();
      n_cmp++;
      if (rif.rx_valid !== 1'b1 || rif.rx_data !== e) begin
         n_bad++;
         $display("FAIL ferr_next: got %b/%h required 1/%h",
                  rif.rx_valid, rif.rx_data, e);
      end
      do_ack();
   endtask

   task automatic test_overrun();
      logic [7:0] e;
      send_frame(8'h11, 1'b1, CPB);
      n_cmp++;
      if (rif.overrun_err !== 1'b0) begin
         n_bad++;
         $display("FAIL ovr_first: got %b required 0", rif.overrun_err);
      end
      send_frame(8'h22, 1'b1, CPB);
      e = next_exp();
      e = next_exp();
      n_cmp++;
      if (rif.rx_data !== e || rif.rx_valid !== 1'b1
          || rif.overrun_err !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun: got %h/%b/%b required %h/1/1",
                  rif.rx_data, rif.rx_valid, rif.overrun_err, e);
      end
      do_ack();
      n_cmp++;
      if (rif.rx_valid !== 1'b0 || rif.overrun_err !== 1'b0) begin
         n_bad++;
         $display("FAIL ovr_ack: got %b/%b required 0/0",
                  rif.rx_valid, rif.overrun_err);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      send_frame(8'h5A, 1'b1, CPB);
      e = next_exp();
      n_cmp++;
      if (rif.rx_data !== e || rif.rx_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset: got %h/%b required %h/1",
                  rif.rx_data, rif.rx_valid, e);
      end
      rx_pin = 1'b0;
      repeat (CPB) @(negedge clk);
      rx_pin = 1'b1;
      repeat (4 * CPB + 60) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if ({rif.rx_data, rif.rx_valid, rif.rx_busy, rif.frame_err,
           rif.overrun_err} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_mid: got %h/%b%b%b%b required 00/0000",
                  rif.rx_data, rif.rx_valid, rif.rx_busy,
                  rif.frame_err, rif.overrun_err);
      end
      repeat (5 * CPB) @(negedge clk);
      send_frame(8'h81, 1'b1, CPB);
      e = next_exp();
      n_cmp++;
      if (rif.rx_data !== e || rif.rx_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_next: got %h/%b required %h/1",
                  rif.rx_data, rif.rx_valid, e);
      end
      do_ack();
   endtask

   task automatic test_skew();
      logic [7:0] e;
      int pers[2];
      pers[0] = 134;
      pers[1] = 142;
      for (int k = 0; k < 2; k++) begin
         repeat (10) @(negedge clk);
         send_frame(8'hA5, 1'b1, pers[k]);
         e = next_exp();
         n_cmp++;
         if (rif.rx_data !== e || rif.rx_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL skew_%0d: got %h/%b required %h/1",
                     pers[k], rif.rx_data, rif.rx_valid, e);
         end
         do_ack();
      end
   endtask

   initial begin
      rif.rx_ack = 1'b0;
      @(negedge clk);
      test_reset();
      test_idle();
      test_single();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid();
      test_skew();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
